// File: rtl/ysyx_22050019_pkg.sv
// Shared definitions for the ysyx_22050019 instruction fetch unit.
// Holds the fetch FSM encoding, reset PC default and instruction width.
package ysyx_22050019_pkg;

    localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          INST_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } ifu_state_e;

    // Picks the 32-bit instruction out of a 64-bit memory beat using pc[2].
    function automatic logic [INST_W-1:0] select_word(input logic [63:0] data, input logic hi);
        return hi ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22050019_ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps one read in flight to instruction memory and
// presents {pc_o, inst_o, commite_o} with a one-cycle ifu_ok_o strobe.
//
// state | meaning
// IDLE  | first cycle after reset release
// REQ   | request presented, waiting for memory to accept it
// WAIT  | request accepted, waiting for its response (drop_q marks it stale)
// HOLD  | instruction presented but IF/ID stalled; PC not yet advanced
module ysyx_22050019_ifu_fetch
    import ysyx_22050019_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_resp_data_i,
    input  logic              mem_resp_err_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              if_id_stall_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              commite_o,
    output logic              ifu_ok_o,
    output logic              ifu_err_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              commit_q, commit_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              req_fire;

    assign mem_req_valid_o = (state_q == ST_REQ);
    assign mem_req_addr_o  = pc_q & ALIGN_MASK;
    assign req_fire        = mem_req_valid_o & mem_req_ready_i;

    assign pc_o      = pc_out_q;
    assign inst_o    = inst_q;
    assign commite_o = commit_q;
    assign ifu_ok_o  = ok_q;
    assign ifu_err_o = err_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        pc_out_d = pc_out_q;
        inst_d   = inst_q;
        commit_d = commit_q;
        ok_d     = 1'b0;
        err_d    = err_q;

        if (redirect_valid_i) begin
            // A redirect overrides everything; an in-flight read is marked stale.
            pc_d     = redirect_pc_i & ALIGN_MASK;
            commit_d = 1'b0;
            unique case (state_q)
                ST_REQ: begin
                    state_d = req_fire ? ST_WAIT : ST_REQ;
                    drop_d  = req_fire;
                end
                ST_WAIT: begin
                    state_d = mem_resp_valid_i ? ST_REQ : ST_WAIT;
                    drop_d  = ~mem_resp_valid_i;
                end
                default: begin
                    state_d = ST_REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (req_fire) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_resp_valid_i) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            pc_out_d = pc_q;
                            inst_d   = select_word(64'(mem_resp_data_i), pc_q[2]);
                            err_d    = mem_resp_err_i;
                            commit_d = 1'b1;
                            ok_d     = 1'b1;
                            if (if_id_stall_i) begin
                                state_d = ST_HOLD;
                            end else begin
                                pc_d    = pc_q + PC_STEP;
                                state_d = ST_REQ;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (!if_id_stall_i) begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            pc_out_q <= '0;
            inst_q   <= '0;
            commit_q <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
            commit_q <= commit_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_ifu_fetch.sv
// Bench for the fetch unit: memory model, transaction-level reference checked every cycle,
// and directed scenarios with literal expectations.
module tb_ysyx_22050019_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] HKEY   = 32'h1357_9bdf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [63:0] mem_req_addr_o;
    logic        mem_resp_valid_i = 1'b0;
    logic [63:0] mem_resp_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    logic        mem_resp_err_i   = 1'b0;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        if_id_stall_i;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic        commite_o;
    logic        ifu_ok_o;
    logic        ifu_err_o;

    int total = 0;
    int bad   = 0;

    int          lat    = 1;
    logic [63:0] err_pc = 64'hFFFF_FFFF_FFFF_FFFF;

    ysyx_22050019_ifu_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_err_i   (mem_resp_err_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .if_id_stall_i    (if_id_stall_i),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .commite_o        (commite_o),
        .ifu_ok_o         (ifu_ok_o),
        .ifu_err_o        (ifu_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit good, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!good) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image: one special doubleword at the reset PC, a hash of the address elsewhere.
    function automatic logic [63:0] mem_dw(input logic [63:0] a);
        logic [63:0] base;
        base = {a[63:3], 3'b000};
        if (base == RST_PC) return 64'h00100093_00000413;
        return {(base[31:0] | 32'h4) ^ HKEY, base[31:0] ^ HKEY};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        logic [63:0] dw;
        dw = mem_dw(pc);
        return pc[2] ? dw[63:32] : dw[31:0];
    endfunction

    // Memory: answers each accepted request after 'lat' cycles.
    int          cd = 0;
    logic [63:0] m_addr = '0;

    always @(negedge clk) begin
        if (rst_n && mem_req_valid_o && mem_req_ready_i) begin
            cd     = lat;
            m_addr = mem_req_addr_o;
        end
    end

    always @(posedge clk) begin
        #1;
        mem_resp_valid_i = 1'b0;
        mem_resp_err_i   = 1'b0;
        mem_resp_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
        if (!rst_n) begin
            cd = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = mem_dw(m_addr);
                mem_resp_err_i   = (m_addr == err_pc);
            end
        end
    end

    // Reference: tracks what must be presented, from requests, responses and redirects.
    logic        ok_due, due_err, pres_err, exp_commit, outstanding, stale;
    logic [63:0] due_pc, pres_pc, pc_exp, out_addr;
    logic [31:0] pres_inst;

    always @(negedge clk) begin
        if (!rst_n) begin
            ok_due      = 1'b0;
            due_err     = 1'b0;
            due_pc      = '0;
            pres_pc     = '0;
            pres_inst   = '0;
            pres_err    = 1'b0;
            exp_commit  = 1'b0;
            outstanding = 1'b0;
            stale       = 1'b0;
            pc_exp      = RST_PC;
            out_addr    = '0;
        end else begin
            chk(ifu_ok_o === ok_due, "ok_strobe", 64'(ifu_ok_o), 64'(ok_due));
            if (ok_due) begin
                pres_pc    = due_pc;
                pres_inst  = exp_inst(due_pc);
                pres_err   = due_err;
                exp_commit = 1'b1;
            end
            chk(pc_o === pres_pc, "pc_o", pc_o, pres_pc);
            chk(inst_o === pres_inst, "inst_o", 64'(inst_o), 64'(pres_inst));
            chk(ifu_err_o === pres_err, "ifu_err_o", 64'(ifu_err_o), 64'(pres_err));
            chk(commite_o === exp_commit, "commite_o", 64'(commite_o), 64'(exp_commit));
            ok_due = 1'b0;
            if (mem_resp_valid_i) begin
                chk(outstanding, "resp_without_req", 64'(outstanding), 64'd1);
                if (!stale && !redirect_valid_i) begin
                    ok_due  = 1'b1;
                    due_pc  = out_addr;
                    due_err = (out_addr == err_pc);
                    pc_exp  = out_addr + 64'd4;
                end
                outstanding = 1'b0;
                stale       = 1'b0;
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
                chk(!outstanding, "second_outstanding", 64'(outstanding), 64'd0);
                if (!redirect_valid_i)
                    chk(mem_req_addr_o === pc_exp, "req_addr", mem_req_addr_o, pc_exp);
                outstanding = 1'b1;
                out_addr    = mem_req_addr_o;
            end
            if (redirect_valid_i) begin
                if (outstanding) stale = 1'b1;
                pc_exp     = redirect_pc_i & ~64'h3;
                exp_commit = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ok(input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            seen = ifu_ok_o;
        end
        chk(seen, "wait_ok_timeout", 64'(seen), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(pc_o === 64'd0 && inst_o === 32'd0 && commite_o === 1'b0 && ifu_ok_o === 1'b0
            && ifu_err_o === 1'b0 && mem_req_valid_o === 1'b0, tag,
            {pc_o[31:0], inst_o[27:0], commite_o, ifu_ok_o, ifu_err_o, mem_req_valid_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit seen_ok, seen_req;
        rst_n            = 1'b0;
        mem_req_ready_i  = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        if_id_stall_i    = 1'b0;
        #12;
        chk_all_zero("reset_outputs");
        #5 rst_n = 1'b1;

        // 1: first fetch from the reset PC
        wait_ok(20);
        chk(pc_o === 64'h8000_0000, "t1_pc", pc_o, 64'h8000_0000);
        chk(inst_o === 32'h0000_0413, "t1_inst", 64'(inst_o), 64'h413);
        chk(mem_req_valid_o && mem_req_addr_o === 64'h8000_0004, "t1_next_req", mem_req_addr_o, 64'h8000_0004);
        if_id_stall_i = 1'b1;
        tick();
        chk(ifu_ok_o === 1'b0, "t1_ok_one_cycle", 64'(ifu_ok_o), 64'd0);

        // 2: response lands while stalled
        wait_ok(20);
        chk(inst_o === 32'h0010_0093, "t2_inst_hi", 64'(inst_o), 64'h0010_0093);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk(!ifu_ok_o && !mem_req_valid_o && pc_o === 64'h8000_0004, "t2_hold",
                {pc_o[61:0], ifu_ok_o, mem_req_valid_o}, {62'h8000_0004, 2'b00});
        end
        lat           = 3;
        if_id_stall_i = 1'b0;
        tick();
        chk(mem_req_valid_o && mem_req_addr_o === 64'h8000_0008, "t2_resume_req", mem_req_addr_o, 64'h8000_0008);

        // 3: redirect while the read is in flight
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0100;
        tick();
        redirect_valid_i = 1'b0;
        chk(commite_o === 1'b0, "t3_commit_cleared", 64'(commite_o), 64'd0);
        seen_ok  = 1'b0;
        seen_req = 1'b0;
        for (int i = 0; i < 10 && !seen_req; i++) begin
            tick();
            seen_ok  = seen_ok | ifu_ok_o;
            seen_req = mem_req_valid_o;
        end
        chk(seen_req && !seen_ok && mem_req_addr_o === 64'h8000_0100, "t3_redirect_req",
            mem_req_addr_o, 64'h8000_0100);

        // 4: redirect coinciding with the response; low bits of target ignored
        seen_ok = 1'b0;
        for (int i = 0; i < 10 && !seen_ok; i++) begin
            tick();
            seen_ok = mem_resp_valid_i;
        end
        chk(seen_ok, "t4_resp_timeout", 64'(seen_ok), 64'd1);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0103;
        tick();
        redirect_valid_i = 1'b0;
        chk(!ifu_ok_o && mem_req_valid_o && mem_req_addr_o === 64'h8000_0100, "t4_discard",
            mem_req_addr_o, 64'h8000_0100);
        wait_ok(20);
        chk(pc_o === 64'h8000_0100, "t4_pc", pc_o, 64'h8000_0100);

        // 5: memory not ready for 4 cycles, then an access fault
        mem_req_ready_i = 1'b0;
        err_pc          = 64'h8000_0104;
        lat             = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk(mem_req_valid_o && mem_req_addr_o === 64'h8000_0104, "t5_req_held",
                mem_req_addr_o, 64'h8000_0104);
        end
        mem_req_ready_i = 1'b1;
        wait_ok(20);
        chk(ifu_err_o === 1'b1 && pc_o === 64'h8000_0104, "t5_err", {pc_o[62:0], ifu_err_o}, {63'h8000_0104, 1'b1});

        // 6: redirect during an accepted request to the top of memory, wrap, async reset mid-read
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid_i = 1'b0;
        err_pc           = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_ok(20);
        chk(pc_o === 64'hFFFF_FFFF_FFFF_FFFC, "t6_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk(mem_req_valid_o && mem_req_addr_o === 64'd0, "t6_wrap", mem_req_addr_o, 64'd0);
        lat = 3;
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async_reset");
        tick();
        tick();
        rst_n = 1'b1;
        lat   = 1;
        wait_ok(20);
        chk(pc_o === 64'h8000_0000 && inst_o === 32'h0000_0413, "t6_restart", pc_o, 64'h8000_0000);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
